// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES-128 round sequencer: FSM states, datapath stage codes,
// counter sizing and the latency range check used at elaboration.
package aes_ctrl_pkg;

  localparam int NR_DEFAULT = 10;
  localparam int CNT_W      = 6;
  localparam int LAT_MAX    = (1 << CNT_W) - 1;

  typedef logic [2:0] fsm_state_t;
  typedef logic [2:0] stage_code_t;

  localparam fsm_state_t S_IDLE  = 3'd0;
  localparam fsm_state_t S_KEY   = 3'd1;
  localparam fsm_state_t S_ARK   = 3'd2;
  localparam fsm_state_t S_SUB   = 3'd3;
  localparam fsm_state_t S_SHIFT = 3'd4;
  localparam fsm_state_t S_MIX   = 3'd5;
  localparam fsm_state_t S_DONE  = 3'd6;

  // Codes seen by the datapath capture mux; ST_NONE means "capture nothing".
  localparam stage_code_t ST_NONE = 3'd0;
  localparam stage_code_t ST_KEY  = 3'd1;
  localparam stage_code_t ST_ARK  = 3'd2;
  localparam stage_code_t ST_SUB  = 3'd3;
  localparam stage_code_t ST_SR   = 3'd4;
  localparam stage_code_t ST_MC   = 3'd5;

  function automatic stage_code_t stage_of(input fsm_state_t s);
    stage_code_t code;
    code = ST_NONE;
    case (s)
      S_KEY:   code = ST_KEY;
      S_ARK:   code = ST_ARK;
      S_SUB:   code = ST_SUB;
      S_SHIFT: code = ST_SR;
      S_MIX:   code = ST_MC;
      default: code = ST_NONE;
    endcase
    return code;
  endfunction

  function automatic bit lat_in_range(input int lat);
    return (lat >= 1) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter timing one datapath stage. expire_o is registered and is high
// exactly in the cycle the count reads 1, i.e. the last cycle of the stage.
module lat_counter
  import aes_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;
  logic         expire_q, expire_d;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    count_d  = count_q;
    expire_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d  = value_i;
      expire_d = (value_i == W'(1));
    end else if (count_q != '0) begin
      count_d  = count_q - W'(1);
      expire_d = (count_q == W'(2));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for one AES-128 encryption over the iterative round datapath:
// pulses each stage enable, times its latency and tells the datapath what to capture.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR      = NR_DEFAULT,
  parameter int LAT_KEY = 4,
  parameter int LAT_ARK = 1,
  parameter int LAT_SUB = 17,
  parameter int LAT_SR  = 1,
  parameter int LAT_MC  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] round,
  output logic [2:0] stage,
  output logic       en_key,
  output logic       en_ark,
  output logic       en_sub,
  output logic       en_shift,
  output logic       en_mix,
  output logic       state_cap,
  output logic       first
);

  if (!(lat_in_range(LAT_KEY) && lat_in_range(LAT_ARK) && lat_in_range(LAT_SUB) &&
        lat_in_range(LAT_SR) && lat_in_range(LAT_MC))) begin : g_lat_range_error
    $error("aes_round_sequencer: every LAT_* must be in 1..63");
  end
  if (NR < 1 || NR > 15) begin : g_nr_range_error
    $error("aes_round_sequencer: NR must fit the 4-bit round counter (1..15)");
  end

  localparam logic [3:0]       NR_W      = 4'(NR);
  localparam logic [CNT_W-1:0] LAT_KEY_W = CNT_W'(LAT_KEY);
  localparam logic [CNT_W-1:0] LAT_ARK_W = CNT_W'(LAT_ARK);
  localparam logic [CNT_W-1:0] LAT_SUB_W = CNT_W'(LAT_SUB);
  localparam logic [CNT_W-1:0] LAT_SR_W  = CNT_W'(LAT_SR);
  localparam logic [CNT_W-1:0] LAT_MC_W  = CNT_W'(LAT_MC);

  fsm_state_t       state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             first_q, first_d;
  stage_code_t      stage_q, stage_d;
  logic [4:0]       en_q, en_d;       // {key, ark, sub, shift, mix}
  logic             entering;
  logic             stage_last;
  logic [CNT_W-1:0] lat_sel;

  // The counter is loaded in the enable cycle of each stage with that stage's latency.
  always_comb begin
    lat_sel = LAT_KEY_W;
    case (state_q)
      S_ARK:   lat_sel = LAT_ARK_W;
      S_SUB:   lat_sel = LAT_SUB_W;
      S_SHIFT: lat_sel = LAT_SR_W;
      S_MIX:   lat_sel = LAT_MC_W;
      default: lat_sel = LAT_KEY_W;
    endcase
  end

  lat_counter #(.W(CNT_W)) u_lat_counter (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (abort),
    .load_i   (|en_q),
    .value_i  (lat_sel),
    .expire_o (stage_last)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        round_d = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_KEY;
            round_d = '0;
          end
        end
        S_KEY:   if (stage_last) state_d = (round_q == '0) ? S_ARK : S_SUB;
        S_SUB:   if (stage_last) state_d = S_SHIFT;
        S_SHIFT: if (stage_last) state_d = (round_q == NR_W) ? S_ARK : S_MIX;
        S_MIX:   if (stage_last) state_d = S_ARK;
        S_ARK: begin
          if (stage_last) begin
            if (round_q == NR_W) begin
              state_d = S_DONE;
            end else begin
              state_d = S_KEY;
              round_d = round_q + 4'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so start/abort only
  // reach the pins through a flop.
  always_comb begin
    entering = (state_d != state_q);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    stage_d  = stage_of(state_d);
    first_d  = busy_d && (round_d == '0);
    en_d     = '0;
    if (entering) begin
      case (state_d)
        S_KEY:   en_d = 5'b10000;
        S_ARK:   en_d = 5'b01000;
        S_SUB:   en_d = 5'b00100;
        S_SHIFT: en_d = 5'b00010;
        S_MIX:   en_d = 5'b00001;
        default: en_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      first_q <= 1'b0;
      stage_q <= ST_NONE;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      first_q <= first_d;
      stage_q <= stage_d;
      en_q    <= en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign round     = round_q;
  assign stage     = stage_q;
  assign en_key    = en_q[4];
  assign en_ark    = en_q[3];
  assign en_sub    = en_q[2];
  assign en_shift  = en_q[1];
  assign en_mix    = en_q[0];
  assign state_cap = stage_last;
  assign first     = first_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a schedule-based reference model predicts
// every output in every cycle under directed and randomized start/abort/reset stimulus.
`timescale 1ns/1ps
module tb_aes_round_sequencer;
  import aes_ctrl_pkg::*;

  localparam int NR = 10;
  localparam int LK = 4;
  localparam int LA = 1;
  localparam int LS = 17;
  localparam int LR = 1;
  localparam int LM = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, en_key, en_ark, en_sub, en_shift, en_mix, state_cap, first;
  logic [3:0] round;
  logic [2:0] stage;

  aes_round_sequencer #(
    .NR(NR), .LAT_KEY(LK), .LAT_ARK(LA), .LAT_SUB(LS), .LAT_SR(LR), .LAT_MC(LM)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .round(round), .stage(stage),
    .en_key(en_key), .en_ark(en_ark), .en_sub(en_sub), .en_shift(en_shift), .en_mix(en_mix),
    .state_cap(state_cap), .first(first)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one encryption is a flat list of per-cycle slots built from the
  // round recipe; the model only tracks a position in that list.
  typedef struct {
    logic [2:0] stage;
    logic [3:0] rnd;
    logic [4:0] en;    // {key, ark, sub, shift, mix}
    logic       cap;
  } slot_t;

  slot_t      sched[$];
  int         m_pos = -1;          // -1 idle, sched.size() is the DONE cycle
  logic [3:0] m_idle_round = 4'd0;
  int         cyc = 0;

  function automatic int lat_of(input logic [2:0] code);
    case (code)
      ST_KEY:  return LK;
      ST_ARK:  return LA;
      ST_SUB:  return LS;
      ST_SR:   return LR;
      default: return LM;
    endcase
  endfunction

  function automatic logic [4:0] en_mask(input logic [2:0] code);
    case (code)
      ST_KEY:  return 5'b10000;
      ST_ARK:  return 5'b01000;
      ST_SUB:  return 5'b00100;
      ST_SR:   return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic add_stage(input logic [2:0] code, input int rnd);
    slot_t s;
    for (int j = 0; j <= lat_of(code); j++) begin
      s.stage = code;
      s.rnd   = rnd[3:0];
      s.en    = (j == 0) ? en_mask(code) : 5'b0;
      s.cap   = (j == lat_of(code));
      sched.push_back(s);
    end
  endtask

  task automatic build_schedule();
    add_stage(ST_KEY, 0);
    add_stage(ST_ARK, 0);
    for (int r = 1; r <= NR; r++) begin
      add_stage(ST_KEY, r);
      add_stage(ST_SUB, r);
      add_stage(ST_SR, r);
      if (r != NR) add_stage(ST_MC, r);
      add_stage(ST_ARK, r);
    end
  endtask

  task automatic model_edge(input logic s, input logic a, input logic r);
    if (r) begin
      m_pos = -1;
      m_idle_round = 4'd0;
    end else if (m_pos >= 0) begin
      if (a) begin
        m_pos = -1;
        m_idle_round = 4'd0;
      end else if (m_pos == sched.size()) begin
        m_pos = -1;
        m_idle_round = 4'(NR);
      end else begin
        m_pos++;
      end
    end else if (s && !a) begin
      m_pos = 0;
    end
  endtask

  // Word layout: {busy, done, round, stage, en_key, en_ark, en_sub, en_shift, en_mix, state_cap, first}
  function automatic logic [15:0] exp_word();
    slot_t s;
    if (m_pos < 0) return {2'b00, m_idle_round, ST_NONE, 5'b0, 2'b00};
    if (m_pos == sched.size()) return {2'b11, 4'(NR), ST_NONE, 5'b0, 2'b00};
    s = sched[m_pos];
    return {2'b10, s.rnd, s.stage, s.en, s.cap, (s.rnd == 4'd0)};
  endfunction

  function automatic logic [15:0] dut_word();
    return {busy, done, round, stage, en_key, en_ark, en_sub, en_shift, en_mix, state_cap, first};
  endfunction

  task automatic tick(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    reset = r;
    @(posedge clock);
    model_edge(s, a, r);
    cyc++;
    #1;
    check($sformatf("outputs@%0d", cyc), 32'(dut_word()), 32'(exp_word()));
  endtask

  // One full encryption from idle, with the timing landmarks the recipe fixes.
  task automatic measure_run(input string tag);
    int start_cyc = -1, done_cyc = -1, busy_cnt = 0;
    int n_key = 0, n_ark = 0, n_sub = 0, n_sr = 0, n_mc = 0;
    int sub5_en = -1, sub5_cap = -1, ark10_cap = -1, mc10 = 0;
    for (int i = 0; i < 306; i++) begin
      tick(i == 0, 1'b0, 1'b0);
      if (i == 0) start_cyc = cyc - 1;
      busy_cnt += int'(busy);
      n_key += int'(en_key);
      n_ark += int'(en_ark);
      n_sub += int'(en_sub);
      n_sr  += int'(en_shift);
      n_mc  += int'(en_mix);
      if (en_sub && round == 4'd5) sub5_en = cyc;
      if (state_cap && stage == ST_SUB && round == 4'd5) sub5_cap = cyc;
      if (state_cap && stage == ST_ARK && round == 4'd10) ark10_cap = cyc;
      if (round == 4'd10 && stage == ST_MC) mc10++;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    check({tag, "_done_latency"}, 32'(done_cyc - start_cyc), 32'd296);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd296);
    check({tag, "_en_key_count"}, 32'(n_key), 32'd11);
    check({tag, "_en_ark_count"}, 32'(n_ark), 32'd11);
    check({tag, "_en_sub_count"}, 32'(n_sub), 32'd10);
    check({tag, "_en_shift_count"}, 32'(n_sr), 32'd10);
    check({tag, "_en_mix_count"}, 32'(n_mc), 32'd9);
    check({tag, "_r5_sub_cap_delay"}, 32'(sub5_cap - sub5_en), 32'd17);
    check({tag, "_r10_mc_cycles"}, 32'(mc10), 32'd0);
    check({tag, "_done_after_last_ark"}, 32'(done_cyc - ark10_cap), 32'd1);
  endtask

  initial begin
    int dn[$];
    int keys0[$];
    int cnt;
    bit found;
    logic rs, ra, rr;

    build_schedule();

    // Reset for two cycles, then a full run.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_outputs", 32'(dut_word()), 32'd0);
    measure_run("run1");

    // start held high: back-to-back runs separated by a single IDLE cycle.
    for (int i = 0; i < 600; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (done) dn.push_back(cyc);
      if (en_key && round == 4'd0) keys0.push_back(cyc);
    end
    check("hold_run_starts", 32'(keys0.size()), 32'd3);
    check("hold_restart_gap", (dn.size() > 0 && keys0.size() > 1) ? 32'(keys0[1] - dn[0]) : 32'hffff_ffff, 32'd2);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b0, 1'b0);

    // start and abort together while idle.
    tick(1'b1, 1'b1, 1'b0);
    check("start_abort_idle_busy", 32'(busy), 32'd0);

    // abort 100 cycles after start, then a clean run.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_round", 32'(round), 32'd0);
    cnt = 0;
    for (int i = 0; i < 350; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      cnt += int'(done);
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    measure_run("after_abort");

    // reset a few cycles into the round-3 SubBytes stage.
    tick(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (stage == ST_SUB && round == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_r3_sub", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_mid_sub_outputs", 32'(dut_word()), 32'd0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      cnt += int'(en_sub);
    end
    check("reset_mid_sub_no_en_sub", 32'(cnt), 32'd0);

    // Randomized start/abort/reset traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 15) == 0);
      ra = ($urandom_range(0, 299) == 0);
      rr = ($urandom_range(0, 1499) == 0);
      tick(rs, ra, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
